// File: rtl/udp_port_filter.sv
// udp_port_filter: UDP RX destination-port filter; optional length check via UDP_PORT_FILTER_LEN_CHECK_EN
module udp_port_filter #(
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_enable,
  input  logic [15:0]               cfg_port,
  input  logic [15:0]               cfg_mask,
  input  logic                      s_udp_hdr_valid,
  output logic                      s_udp_hdr_ready,
  input  logic [31:0]               s_ip_source_ip,
  input  logic [31:0]               s_ip_dest_ip,
  input  logic [15:0]               s_udp_source_port,
  input  logic [15:0]               s_udp_dest_port,
  input  logic [15:0]               s_udp_length,
  input  logic [15:0]               s_udp_checksum,
  input  logic [7:0]                s_udp_payload_axis_tdata,
  input  logic                      s_udp_payload_axis_tvalid,
  output logic                      s_udp_payload_axis_tready,
  input  logic                      s_udp_payload_axis_tlast,
  input  logic                      s_udp_payload_axis_tuser,
  output logic                      m_udp_hdr_valid,
  input  logic                      m_udp_hdr_ready,
  output logic [31:0]               m_ip_source_ip,
  output logic [31:0]               m_ip_dest_ip,
  output logic [15:0]               m_udp_source_port,
  output logic [15:0]               m_udp_dest_port,
  output logic [15:0]               m_udp_length,
  output logic [15:0]               m_udp_checksum,
  output logic [7:0]                m_udp_payload_axis_tdata,
  output logic                      m_udp_payload_axis_tvalid,
  input  logic                      m_udp_payload_axis_tready,
  output logic                      m_udp_payload_axis_tlast,
  output logic                      m_udp_payload_axis_tuser,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      drop_pulse,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;
  state_t state, state_nxt;
  logic   port_hit, match, accept;
  assign port_hit = ((s_udp_dest_port ^ cfg_port) & cfg_mask) == 16'd0;
`ifdef UDP_PORT_FILTER_LEN_CHECK_EN
  assign match = !cfg_enable || (port_hit && s_udp_length >= 16'd8);
`else
  assign match = !cfg_enable || port_hit;
`endif
  assign accept = state == IDLE && s_udp_hdr_valid;
  assign busy = state != IDLE;
  assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
  assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
  assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;
  // next state and handshakes; payload is a combinational pass-through while forwarding
  always_comb begin
    state_nxt = state;
    s_udp_hdr_ready = 1'b0;
    s_udp_payload_axis_tready = 1'b0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_hdr_valid = 1'b0;
    case (state)
      IDLE: begin
        s_udp_hdr_ready = 1'b1;
        if (s_udp_hdr_valid) state_nxt = match ? HDR : DROP;
      end
      HDR: begin
        m_udp_hdr_valid = 1'b1;
        if (m_udp_hdr_ready) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        m_udp_payload_axis_tvalid = s_udp_payload_axis_tvalid;
        s_udp_payload_axis_tready = m_udp_payload_axis_tready;
        if (s_udp_payload_axis_tvalid && m_udp_payload_axis_tready && s_udp_payload_axis_tlast) state_nxt = IDLE;
      end
      default: begin
        s_udp_payload_axis_tready = 1'b1;
        if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) state_nxt = IDLE;
      end
    endcase
  end
  // state, header capture on accept, and saturating drop statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      m_ip_source_ip <= '0;
      m_ip_dest_ip <= '0;
      m_udp_source_port <= '0;
      m_udp_dest_port <= '0;
      m_udp_length <= '0;
      m_udp_checksum <= '0;
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      drop_pulse <= accept && !match;
      if (accept) begin
        m_ip_source_ip <= s_ip_source_ip;
        m_ip_dest_ip <= s_ip_dest_ip;
        m_udp_source_port <= s_udp_source_port;
        m_udp_dest_port <= s_udp_dest_port;
        m_udp_length <= s_udp_length;
        m_udp_checksum <= s_udp_checksum;
      end
      if (accept && !match && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_udp_port_filter.sv
// tb_udp_port_filter: directed self-checking bench for udp_port_filter
module tb_udp_port_filter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_enable, s_udp_hdr_valid, s_udp_hdr_ready;
  logic [15:0] cfg_port, cfg_mask;
  logic [31:0] s_ip_source_ip, s_ip_dest_ip, m_ip_source_ip, m_ip_dest_ip;
  logic [15:0] s_udp_source_port, s_udp_dest_port, s_udp_length, s_udp_checksum;
  logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [7:0]  s_tdata, m_tdata;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic        m_udp_hdr_valid, m_udp_hdr_ready, drop_pulse, busy;
  logic [15:0] drop_count;
  int          checks = 0, passed = 0, hdr_cnt = 0, mv_cnt = 0, dp_cnt = 0, viol = 0;
  logic [9:0]  out_q[$];
  logic [127:0] exp_hdr, prev_f;
  logic        prev_hold = 1'b0, bp_on = 1'b0;
  wire [127:0] m_f = {m_ip_source_ip, m_ip_dest_ip, m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum};

  always #5 clk = ~clk;

  udp_port_filter #(.DROP_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_port(cfg_port), .cfg_mask(cfg_mask),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
    .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
    .s_udp_length(s_udp_length), .s_udp_checksum(s_udp_checksum),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
    .s_udp_payload_axis_tready(s_tready), .s_udp_payload_axis_tlast(s_tlast),
    .s_udp_payload_axis_tuser(s_tuser),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
    .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tvalid(m_tvalid),
    .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(m_tlast),
    .m_udp_payload_axis_tuser(m_tuser),
    .drop_count(drop_count), .drop_pulse(drop_pulse), .busy(busy)
  );

  // observe the output side midway between clock edges
  always @(negedge clk) begin
    if (m_udp_hdr_valid && m_udp_hdr_ready) hdr_cnt++;
    if (prev_hold && m_udp_hdr_valid && m_f !== prev_f) viol++;
    if (m_udp_hdr_valid && s_tready) viol++;
    prev_hold = m_udp_hdr_valid && !m_udp_hdr_ready;
    prev_f = m_f;
    if (m_tvalid && m_tready) out_q.push_back({m_tuser, m_tlast, m_tdata});
    if (m_tvalid) mv_cnt++;
    if (drop_pulse) dp_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [15:0] dport, input logic [15:0] len);
    logic rdy;
    int   n = 0;
    s_ip_source_ip = 32'h0A000001;
    s_ip_dest_ip = 32'h0A000002;
    s_udp_source_port = 16'h5000;
    s_udp_dest_port = dport;
    s_udp_length = len;
    s_udp_checksum = ~dport;
    exp_hdr = {32'h0A000001, 32'h0A000002, 16'h5000, dport, len, ~dport};
    s_udp_hdr_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = s_udp_hdr_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    s_udp_hdr_valid = 1'b0;
    check("hdr_accept", rdy, 1);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
    logic rdy;
    int   n = 0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tlast = last;
    s_tuser = user;
    do begin
      @(negedge clk);
      rdy = s_tready;
      tick();
      n++;
    end while (!rdy && n < 100);
    s_tvalid = 1'b0;
    if (!rdy) check("beat_timeout", 0, 1);
  endtask

  task automatic send_payload(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) send_beat(base + 8'(i) * step, i == n - 1, i == 1);
  endtask

  task automatic check_payload(input int n, input logic [7:0] base, input logic [7:0] step);
    check("pay_len", out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++)
      check($sformatf("pay_beat%0d", i), out_q[i], {i == 1, i == n - 1, base + 8'(i) * step});
    out_q.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle", busy, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    s_udp_hdr_valid = 1'b0;
    s_tvalid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    out_q.delete();
    hdr_cnt = 0;
    mv_cnt = 0;
    dp_cnt = 0;
    viol = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_enable = 1'b1; cfg_port = 16'h1234; cfg_mask = 16'hFFFF;
    s_udp_hdr_valid = 1'b0; s_ip_source_ip = '0; s_ip_dest_ip = '0;
    s_udp_source_port = '0; s_udp_dest_port = '0; s_udp_length = '0; s_udp_checksum = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_udp_hdr_ready = 1'b1; m_tready = 1'b1;
    tick();
    tick();
    check("rst_hvalid", m_udp_hdr_valid, 0);
    check("rst_fields", m_f, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_hdr_ready", s_udp_hdr_ready, 1);
    check("rst_tready", s_tready, 0);
    rst = 1'b1;
    tick();
    // exact match forwarded with one-cycle header latency
    send_hdr(16'h1234, 16'd12);
    check("t1_hvalid", m_udp_hdr_valid, 1);
    check("t1_fields", m_f, exp_hdr);
    check("t1_busy", busy, 1);
    send_payload(4, 8'hAA, 8'h11);
    wait_idle();
    check_payload(4, 8'hAA, 8'h11);
    check("t1_hdrs", hdr_cnt, 1);
    check("t1_drop_count", drop_count, 0);
    // mismatch consumed and counted
    hdr_cnt = 0; mv_cnt = 0; dp_cnt = 0;
    send_hdr(16'h1235, 16'd11);
    check("t2_pulse", drop_pulse, 1);
    check("t2_hvalid", m_udp_hdr_valid, 0);
    check("t2_tready", s_tready, 1);
    send_payload(3, 8'h01, 8'h01);
    wait_idle();
    check("t2_mvalid", mv_cnt, 0);
    check("t2_hdrs", hdr_cnt, 0);
    check("t2_pulses", dp_cnt, 1);
    check("t2_drop_count", drop_count, 1);
    check("t2_out", out_q.size(), 0);
    // masked compare; cfg change mid-frame has no effect
    apply_reset();
    cfg_port = 16'h1200; cfg_mask = 16'hFF00;
    send_hdr(16'h12FF, 16'd10);
    cfg_port = 16'h9999;
    send_payload(2, 8'h10, 8'h01);
    wait_idle();
    check_payload(2, 8'h10, 8'h01);
    cfg_port = 16'h1200;
    send_hdr(16'h13FF, 16'd10);
    send_payload(2, 8'h20, 8'h01);
    wait_idle();
    check("t3_hdrs", hdr_cnt, 1);
    check("t3_drop_count", drop_count, 1);
    check("t3_pulses", dp_cnt, 1);
    check("t3_out", out_q.size(), 0);
    // header backpressure and random payload backpressure
    cfg_port = 16'h1234; cfg_mask = 16'hFFFF;
    hdr_cnt = 0; viol = 0;
    m_udp_hdr_ready = 1'b0;
    send_hdr(16'h1234, 16'd14);
    bp_on = 1'b1;
    fork
      begin
        repeat (5) tick();
        check("t4_hold_valid", m_udp_hdr_valid, 1);
        check("t4_hold_fields", m_f, exp_hdr);
        check("t4_no_payload", out_q.size(), 0);
        m_udp_hdr_ready = 1'b1;
      end
      begin
        send_payload(6, 8'h30, 8'h07);
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          m_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    m_tready = 1'b1;
    wait_idle();
    check_payload(6, 8'h30, 8'h07);
    check("t4_viol", viol, 0);
    check("t4_hdrs", hdr_cnt, 1);
    // asynchronous reset mid-payload
    apply_reset();
    send_hdr(16'h0BAD, 16'd9);
    send_payload(1, 8'h00, 8'h00);
    wait_idle();
    check("t5_pre_drop", drop_count, 1);
    send_hdr(16'h1234, 16'd12);
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b0);
    s_tvalid = 1'b1; s_tdata = 8'h03; s_tlast = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_hvalid", m_udp_hdr_valid, 0);
    check("t5_mtvalid", m_tvalid, 0);
    check("t5_drop_count", drop_count, 0);
    check("t5_busy", busy, 0);
    check("t5_fields", m_f, 0);
    tick();
    s_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    out_q.delete();
    send_hdr(16'h1234, 16'd12);
    check("t5_fields_new", m_f, exp_hdr);
    send_payload(3, 8'h50, 8'h01);
    wait_idle();
    check_payload(3, 8'h50, 8'h01);
    // short UDP length
    apply_reset();
    send_hdr(16'h1234, 16'd6);
    send_payload(2, 8'h60, 8'h01);
    wait_idle();
`ifdef UDP_PORT_FILTER_LEN_CHECK_EN
    check("t6_len_drop", drop_count, 1);
    check("t6_len_out", out_q.size(), 0);
    out_q.delete();
`else
    check("t6_len_drop", drop_count, 0);
    check_payload(2, 8'h60, 8'h01);
`endif
    // filter disabled passes everything, short length included
    cfg_enable = 1'b0;
    send_hdr(16'h4321, 16'd6);
    send_payload(2, 8'h70, 8'h01);
    wait_idle();
    check_payload(2, 8'h70, 8'h01);
`ifdef UDP_PORT_FILTER_LEN_CHECK_EN
    check("t7_drop_count", drop_count, 1);
`else
    check("t7_drop_count", drop_count, 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/udp_port_filter.md
Name: udp_port_filter

Overview:
- Sits directly downstream of the UDP block's RX output (m_udp_* side) and upstream of the application.
- Accepts UDP header + payload frames and compares destination port against a runtime port/mask.
- Forwards matching frames unchanged; silently consumes and counts non-matching frames.

Parameters:
DROP_CNT_WIDTH, 16, width of saturating dropped-frame counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_enable  in  1  1 = filter active; 0 = pass all frames
cfg_port  in  16  destination port to match
cfg_mask  in  16  per-bit compare mask (1 = compare bit)
s_udp_hdr_valid / s_udp_hdr_ready  in/out  1  input header handshake
s_ip_source_ip, s_ip_dest_ip  in  32  IP addresses
s_udp_source_port, s_udp_dest_port, s_udp_length, s_udp_checksum  in  16  UDP header fields
s_udp_payload_axis_tdata  in  8  payload data
s_udp_payload_axis_tvalid/tready/tlast/tuser  in/out/in/in  1  payload stream
m_udp_hdr_valid / m_udp_hdr_ready  out/in  1  output header handshake
m_ip_source_ip, m_ip_dest_ip  out  32  registered copies
m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum  out  16  registered copies
m_udp_payload_axis_tdata  out  8  payload data
m_udp_payload_axis_tvalid/tready/tlast/tuser  out/in/out/out  1  payload stream
drop_count  out  DROP_CNT_WIDTH  dropped frames, saturating
drop_pulse  out  1  one-cycle strobe per dropped frame
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; m_udp_hdr_valid=0, all m_ header fields 0, drop_count=0, drop_pulse=0, busy=0. Frames in flight are abandoned; no partial output after release.
- States: IDLE, HDR, PAYLOAD, DROP.
- IDLE: s_udp_hdr_ready=1, s_udp_payload_axis_tready=0. On s_udp_hdr_valid, latch all header fields and sample cfg_* (config sampled only here).
- match = !cfg_enable || (((s_udp_dest_port ^ cfg_port) & cfg_mask) == 0).
- If match: go to HDR; m_udp_hdr_valid=1 on the next cycle (1-cycle header latency).
- If no match: go to DROP; drop_pulse=1 for that cycle; drop_count increments, holding at all-ones.
- HDR: s_udp_hdr_ready=0; hold m_udp_hdr_valid and fields stable until m_udp_hdr_ready; then go to PAYLOAD and deassert valid. Payload stalls (tready=0) during HDR.
- PAYLOAD: combinational pass-through.
  - m_tvalid = s_tvalid.
  - s_tready = m_tready.
  - tdata, tlast, tuser pass unchanged.
  - On a transfer with tlast, go to IDLE.
- DROP: s_tready=1, m_tvalid=0. On s_tvalid && tlast, go to IDLE.
- Header-to-next-header minimum spacing: one idle cycle after tlast (IDLE re-entry).
- tuser is never interpreted; it is forwarded in PAYLOAD and discarded in DROP.
- Zero-length payload is not special-cased: every frame must terminate with a tlast beat.
- cfg changes mid-frame do not affect the current frame.

Optional Feature:
- Macro: UDP_PORT_FILTER_LEN_CHECK_EN.
- Defined:
  - Frames with s_udp_length < 8 are dropped and counted regardless of port match.
  - Checked only when cfg_enable=1.
- Undefined: length is not examined; forwarded as-is.

Test Plan:
- cfg_enable=1, port=0x1234, mask=0xFFFF; frame dest_port 0x1234, 4 bytes AA BB CC DD -> header out 1 cycle after accept, identical fields, payload AA..DD with tlast on DD; drop_count=0.
- Same cfg; dest_port 0x1235, 3 bytes -> no m_ valid activity; s_tready=1 throughout; drop_pulse once; drop_count=1.
- mask=0xFF00, port=0x1200; dest_ports 0x12FF then 0x13FF -> first forwarded, second dropped; drop_count=1.
- m_udp_hdr_ready held 0 for 5 cycles, random m_tready backpressure -> header fields stable, no payload accepted before header handshake, byte order intact.
- Assert rst=0 mid-payload of a matching frame -> m_udp_hdr_valid=0, m_tvalid=0, drop_count=0 immediately; next frame after release forwarded correctly.
- With UDP_PORT_FILTER_LEN_CHECK_EN: matching port, s_udp_length=6 -> dropped, drop_count=1. Without the macro -> forwarded.
